// File: rtl/otbn_pkg.sv
// Shared OTBN constants and types used by the behavioural DMEM responder.
package otbn_pkg;

  localparam int WLEN             = 256;
  localparam int BaseIntgWidth    = 39;
  localparam int BaseWordsPerWLEN = WLEN / 32;
  localparam int ExtWLEN          = BaseIntgWidth * BaseWordsPerWLEN;

  typedef enum logic {
    WipeIdle,
    WipeActive
  } dmem_wipe_state_e;

  function automatic int vbits(int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // A slot counts as written only when every one of its bits is enabled.
  function automatic logic [BaseWordsPerWLEN-1:0] full_slots(logic [ExtWLEN-1:0] mask);
    logic [BaseWordsPerWLEN-1:0] full;
    full = '0;
    for (int unsigned k = 0; k < BaseWordsPerWLEN; k++) begin
      full[k] = &mask[k*BaseIntgWidth +: BaseIntgWidth];
    end
    return full;
  endfunction

endpackage

// File: rtl/otbn_dmem_wipe_ctrl.sv
// Row-by-row DMEM wipe sequencer: runs after reset and on each wipe request.
module otbn_dmem_wipe_ctrl
  import otbn_pkg::*;
#(
  parameter  int NumRows = 128,
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wipe_req_i,
  output logic            wipe_busy_o,
  output logic            wipe_we_o,
  output logic [RowW-1:0] wipe_row_o
);

  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  dmem_wipe_state_e state_q, state_d;
  logic [RowW-1:0]  row_q, row_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WipeActive;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      WipeIdle: begin
        if (wipe_req_i) begin
          state_d = WipeActive;
          row_d   = '0;
        end
      end
      WipeActive: begin
        // A new request restarts the sweep even on the final row.
        if (wipe_req_i) begin
          row_d = '0;
        end else if (row_q == LastRow) begin
          state_d = WipeIdle;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: begin
        state_d = WipeActive;
        row_d   = '0;
      end
    endcase
  end

  assign wipe_busy_o = rst_i | (state_q == WipeActive);
  assign wipe_we_o   = (state_q == WipeActive);
  assign wipe_row_o  = row_q;

endmodule

// File: rtl/otbn_dmem_resp.sv
// Behavioural OTBN DMEM: single-cycle read responses, bit-masked writes and
// per-39-bit-word written flags cleared by the wipe sequencer.
module otbn_dmem_resp
  import otbn_pkg::*;
#(
  parameter  int DmemSizeByte  = 4096,
  localparam int DmemAddrWidth = vbits(DmemSizeByte),
  localparam int NumRows       = DmemSizeByte / 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        dmem_req_i,
  input  logic                        dmem_write_i,
  input  logic [DmemAddrWidth-1:0]    dmem_addr_i,
  input  logic [ExtWLEN-1:0]          dmem_wdata_i,
  input  logic [ExtWLEN-1:0]          dmem_wmask_i,
  input  logic [BaseWordsPerWLEN-1:0] dmem_rmask_i,
  output logic [ExtWLEN-1:0]          dmem_rdata_o,
  output logic                        dmem_rvalid_o,
  output logic                        dmem_rerror_o,
  input  logic                        wipe_req_i,
  output logic                        wipe_busy_o
);

  localparam int RowW     = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int RowAddrW = DmemAddrWidth - 5;

  logic [ExtWLEN-1:0]          mem     [NumRows];
  logic [BaseWordsPerWLEN-1:0] written [NumRows];

  logic                wipe_busy;
  logic                wipe_we;
  logic [RowW-1:0]     wipe_row;
  logic [RowAddrW-1:0] row;
  logic [4:0]          unused_addr_lsbs;
  logic                wr_en;
  logic                rd_en;

  otbn_dmem_wipe_ctrl #(
    .NumRows(NumRows)
  ) u_wipe_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wipe_req_i (wipe_req_i),
    .wipe_busy_o(wipe_busy),
    .wipe_we_o  (wipe_we),
    .wipe_row_o (wipe_row)
  );

  assign row              = dmem_addr_i[DmemAddrWidth-1:5];
  assign unused_addr_lsbs = dmem_addr_i[4:0];
  assign wr_en            = dmem_req_i & dmem_write_i & ~wipe_busy;
  assign rd_en            = dmem_req_i & ~dmem_write_i;
  assign wipe_busy_o      = wipe_busy;

  // wipe_we implies wipe_busy, so the wipe and a bus write never collide.
  always_ff @(posedge clk_i) begin
    if (wipe_we) begin
      mem[wipe_row]     <= '0;
      written[wipe_row] <= '0;
    end else if (wr_en) begin
      mem[row]     <= (mem[row] & ~dmem_wmask_i) | (dmem_wdata_i & dmem_wmask_i);
      written[row] <= written[row] | full_slots(dmem_wmask_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_rvalid_o <= 1'b0;
      dmem_rerror_o <= 1'b0;
      dmem_rdata_o  <= '0;
    end else begin
      dmem_rvalid_o <= rd_en;
      if (rd_en) begin
        if (wipe_busy) begin
          dmem_rdata_o  <= '0;
          dmem_rerror_o <= 1'b1;
        end else begin
          dmem_rdata_o  <= mem[row];
          dmem_rerror_o <= |(dmem_rmask_i & ~written[row]);
        end
      end
    end
  end

endmodule

// File: tb/tb_otbn_dmem_resp.sv
// Scoreboard bench for otbn_dmem_resp: reads push expectations, a negedge
// monitor pops and compares every response cycle.
module tb_otbn_dmem_resp;
  import otbn_pkg::*;

  localparam int NR        = 128;
  localparam int W         = ExtWLEN;
  localparam int WaitLimit = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [11:0]   addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  wmask = '0;
  logic [7:0]    rmask = '0;
  logic          wipe_req = 1'b0;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          rerror;
  logic          busy;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [W-1:0] ref_mem  [NR];
  logic [7:0]   ref_flag [NR];

  otbn_dmem_resp #(
    .DmemSizeByte(4096)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dmem_req_i   (req),
    .dmem_write_i (wr),
    .dmem_addr_i  (addr),
    .dmem_wdata_i (wdata),
    .dmem_wmask_i (wmask),
    .dmem_rmask_i (rmask),
    .dmem_rdata_o (rdata),
    .dmem_rvalid_o(rvalid),
    .dmem_rerror_o(rerror),
    .wipe_req_i   (wipe_req),
    .wipe_busy_o  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      n_assert++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (rvalid !== 1'b1 || rdata !== e.data || rerror !== e.err) begin
          n_fail++;
          $display("FAIL read_resp @%0d: rvalid=%b rerror=%b rdata=%h, expected rvalid=1 rerror=%b rdata=%h",
                   cyc, rvalid, rerror, rdata, e.err, e.data);
        end
      end else if (rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_rvalid @%0d: rvalid=%b, expected 0", cyc, rvalid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  function automatic logic [7:0] slot_full(logic [W-1:0] m);
    logic [7:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[k] = &m[k*BaseIntgWidth +: BaseIntgWidth];
    return f;
  endfunction

  task automatic ref_write(input int row, input logic [W-1:0] d, input logic [W-1:0] m);
    ref_mem[row]  = (ref_mem[row] & ~m) | (d & m);
    ref_flag[row] = ref_flag[row] | slot_full(m);
  endtask

  task automatic ref_wipe();
    for (int r = 0; r < NR; r++) begin
      ref_mem[r]  = '0;
      ref_flag[r] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    req = 1'b1; wr = 1'b1; addr = a; wdata = d; wmask = m;
    step();
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] rm,
                         input logic [W-1:0] exp_d, input logic exp_e);
    sb.push_back('{data: exp_d, err: exp_e, due: cyc + 1});
    req = 1'b1; wr = 1'b0; addr = a; rmask = rm;
    step();
    req = 1'b0;
  endtask

  task automatic read_ref(input logic [11:0] a, input logic [7:0] rm);
    int row;
    row = int'(a[11:5]);
    do_read(a, rm, ref_mem[row], |(rm & ~ref_flag[row]));
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WaitLimit; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || rerror !== 1'b0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rvalid=%b rerror=%b rdata_nonzero=%b, expected busy=1 rvalid=0 rerror=0 rdata=0",
               busy, rvalid, rerror, |rdata);
    end
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    ref_wipe();
    bad = 0;
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
      step();
    end
    @(negedge clk);
    n_assert++;
    if (bad != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wipe_busy: %0d low cycles in 0..127, busy@128=%b, expected 0 low cycles and busy@128=0",
               bad, busy);
    end
    do_read(12'h000, 8'h01, '0, 1'b1);
  endtask

  task automatic test_full_write();
    do_write(12'h040, '1, '1);
    ref_write(2, '1, '1);
    do_read(12'h040, 8'hFF, '1, 1'b0);
  endtask

  task automatic test_word_write();
    logic [W-1:0] d;
    logic [W-1:0] m;
    bit ok;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    ref_wipe();
    wait_idle(ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL word_wipe_timeout: busy=%b, expected 0 within %0d cycles", busy, WaitLimit);
    end
    d = '0;
    m = '0;
    d[BaseIntgWidth +: BaseIntgWidth] = 39'h12345678;
    m[BaseIntgWidth +: BaseIntgWidth] = '1;
    do_write(12'h044, d, m);
    ref_write(2, d, m);
    do_read(12'h044, 8'h02, d, 1'b0);
    do_read(12'h044, 8'h04, d, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a_dat;
    logic [W-1:0] b_dat;
    logic [W-1:0] m;
    a_dat = rnd_row();
    b_dat = rnd_row();
    m = rnd_row();
    do_write(12'h0C0, a_dat, '1);
    ref_write(6, a_dat, '1);
    do_write(12'h0C0, b_dat, m);
    ref_write(6, b_dat, m);
    read_ref(12'h0C0, 8'hFF);
    m = '0;
    m[0 +: BaseIntgWidth] = '1;
    m[3*BaseIntgWidth +: 20] = '1;
    do_write(12'h0E0, b_dat, m);
    ref_write(7, b_dat, m);
    read_ref(12'h0E0, 8'h01);
    read_ref(12'h0E0, 8'h08);
    read_ref(12'h0C4, 8'h00);
  endtask

  task automatic test_access_during_wipe();
    bit ok;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    ref_wipe();
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wipe_busy_start: busy=%b, expected 1", busy);
    end
    do_read(12'h040, 8'hFF, '0, 1'b1);
    do_write(12'h060, '1, '1);
    wait_idle(ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL access_wipe_timeout: busy=%b, expected 0 within %0d cycles", busy, WaitLimit);
    end
    do_read(12'h060, 8'hFF, '0, 1'b1);
    do_read(12'h040, 8'h01, '0, 1'b1);
  endtask

  task automatic test_wipe_restart();
    int bad;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    ref_wipe();
    repeat (49) step();
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    bad = 0;
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
      step();
    end
    @(negedge clk);
    n_assert++;
    if (bad != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_busy_len: %0d low cycles after restart, busy@+%0d=%b, expected 0 low and busy=0",
               bad, NR + 1, busy);
    end
  endtask

  task automatic test_collision();
    bit ok;
    req = 1'b1; wr = 1'b1; addr = 12'h080; wdata = '1; wmask = '1; wipe_req = 1'b1;
    step();
    req = 1'b0; wr = 1'b0; wipe_req = 1'b0;
    ref_wipe();
    wait_idle(ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL collision_timeout: busy=%b, expected 0 within %0d cycles", busy, WaitLimit);
    end
    do_read(12'h080, 8'hFF, '0, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    do_write(12'h120, '1, '1);
    ref_write(9, '1, '1);
    req = 1'b1; wr = 1'b0; addr = 12'h120; rmask = 8'hFF; rst = 1'b1;
    step();
    req = 1'b0;
    @(negedge clk);
    n_assert++;
    if (rvalid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_read: rvalid=%b busy=%b, expected rvalid=0 busy=1", rvalid, busy);
    end
    step();
    rst = 1'b0;
    ref_wipe();
    wait_idle(ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_wipe_timeout: busy=%b, expected 0 within %0d cycles", busy, WaitLimit);
    end
    read_ref(12'h120, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_word_write();
    test_back_to_back();
    test_access_during_wipe();
    test_wipe_restart();
    test_collision();
    test_reset_mid_read();
    repeat (3) step();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_responses: %0d outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
